decode_stage_sb: RTL and testbench

- Parametrised successor of the instruction-decode stage: splits the IF_ID word into fields, reads rs/rt from an internal register file, sign-extends the immediate, and produces a one-hot control word into an ID_EX pipeline register.
- Additions over the previous generation:
  - valid/ready handshakes on both sides
  - a writeback port into the register file
  - a RAW scoreboard that stalls dependent instructions
  - flush and halt handling
- Sits between fetch and execute.

---
 rtl/decode_pkg.sv | 94 +++++++++
 rtl/decode_scoreboard.sv | 61 ++++++
 rtl/decode_stage_sb.sv | 167 ++++++++++++++++
 tb/tb_decode_stage_sb.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// ============================================================================
// decode_pkg : opcode map, control-bit indices, instruction field positions
//              and the opcode-to-control decoder shared by the decode stage.
// Rev 1.0
// ============================================================================
`default_nettype none

package decode_pkg;

    localparam int OP_W   = 6;
    localparam int CTRL_N = 15;

    localparam logic [OP_W-1:0] OP_ADD = 6'd0;
    localparam logic [OP_W-1:0] OP_SUB = 6'd1;
    localparam logic [OP_W-1:0] OP_LI  = 6'd2;
    localparam logic [OP_W-1:0] OP_SHL = 6'd3;
    localparam logic [OP_W-1:0] OP_SHR = 6'd4;
    localparam logic [OP_W-1:0] OP_AND = 6'd5;
    localparam logic [OP_W-1:0] OP_OR  = 6'd6;
    localparam logic [OP_W-1:0] OP_XOR = 6'd7;
    localparam logic [OP_W-1:0] OP_BR  = 6'd8;
    localparam logic [OP_W-1:0] OP_BNE = 6'd9;
    localparam logic [OP_W-1:0] OP_MOV = 6'd10;
    localparam logic [OP_W-1:0] OP_ADI = 6'd11;
    localparam logic [OP_W-1:0] OP_MUL = 6'd12;
    localparam logic [OP_W-1:0] OP_HLT = 6'd13;
    localparam logic [OP_W-1:0] OP_NOP = 6'd14;

    localparam int CTRL_ADD = 0;
    localparam int CTRL_SUB = 1;
    localparam int CTRL_LI  = 2;
    localparam int CTRL_SHL = 3;
    localparam int CTRL_SHR = 4;
    localparam int CTRL_AND = 5;
    localparam int CTRL_OR  = 6;
    localparam int CTRL_XOR = 7;
    localparam int CTRL_BR  = 8;
    localparam int CTRL_BNE = 9;
    localparam int CTRL_MOV = 10;
    localparam int CTRL_ADI = 11;
    localparam int CTRL_MUL = 12;
    localparam int CTRL_HLT = 13;
    localparam int CTRL_NOP = 14;

    localparam int F_OP_HI  = 31;
    localparam int F_OP_LO  = 26;
    localparam int F_RS_HI  = 25;
    localparam int F_RS_LO  = 21;
    localparam int F_RT_HI  = 20;
    localparam int F_RT_LO  = 16;
    localparam int F_RD_HI  = 15;
    localparam int F_RD_LO  = 11;
    localparam int F_IMM_HI = 15;
    localparam int F_IMM_LO = 0;

    typedef struct packed {
        logic [CTRL_N-1:0] ctrl;
        logic              wr;
        logic              use_src;
        logic              dst_rt;   // destination taken from rt instead of rd
        logic              illegal;
    } dec_t;

    function automatic dec_t decode_ctrl(input logic [OP_W-1:0] op);
        dec_t d;
        d = '0;
        if (op > OP_NOP) begin
            d.ctrl[CTRL_NOP] = 1'b1;
            d.illegal        = 1'b1;
        end else begin
            d.ctrl    = CTRL_N'(1) << op[3:0];
            d.use_src = 1'b1;
            case (op)
                OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_AND,
                OP_OR, OP_XOR, OP_MUL, OP_MOV: d.wr = 1'b1;
                OP_ADI: begin
                    d.wr     = 1'b1;
                    d.dst_rt = 1'b1;
                end
                OP_LI: begin
                    d.wr      = 1'b1;
                    d.dst_rt  = 1'b1;
                    d.use_src = 1'b0;
                end
                OP_HLT, OP_NOP: d.use_src = 1'b0;
                default: d.wr = 1'b0;
            endcase
        end
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/decode_scoreboard.sv
// ============================================================================
// decode_scoreboard : per-register pending bits with set/clear/flush-clear
//                     and RAW hazard lookup. Honours WB_BYPASS_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module decode_scoreboard #(
    parameter int REG_N = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_set_en,
    input  logic [4:0] i_set_addr,
    input  logic       i_clr_en,
    input  logic [4:0] i_clr_addr,
    input  logic       i_flush_en,
    input  logic [4:0] i_flush_addr,
    input  logic       i_use_src,
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rt,
    output logic       o_hazard
);

    localparam int AW = (REG_N > 1) ? $clog2(REG_N) : 1;

    logic [REG_N-1:0] r_pend;
    logic [REG_N-1:0] w_set_mask;
    logic [REG_N-1:0] w_clr_mask;
    logic [REG_N-1:0] w_flush_mask;
    logic [REG_N-1:0] w_look;

    always_comb begin
        w_set_mask   = '0;
        w_clr_mask   = '0;
        w_flush_mask = '0;
        if (i_set_en)   w_set_mask[i_set_addr[AW-1:0]]     = 1'b1;
        if (i_clr_en)   w_clr_mask[i_clr_addr[AW-1:0]]     = 1'b1;
        if (i_flush_en) w_flush_mask[i_flush_addr[AW-1:0]] = 1'b1;
    end

`ifdef WB_BYPASS_EN
    assign w_look = r_pend & ~w_clr_mask;
`else
    assign w_look = r_pend;
`endif

    assign o_hazard = i_use_src & (w_look[i_rs[AW-1:0]] | w_look[i_rt[AW-1:0]]);

    // Set is applied last so an issue outranks a same-cycle writeback clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr_mask & ~w_flush_mask) | w_set_mask;
        end
    end

endmodule

`default_nettype wire

// File: rtl/decode_stage_sb.sv
// ============================================================================
// decode_stage_sb : instruction decode with register file, RAW scoreboard,
//                   valid/ready handshakes, flush and halt. Option: WB_BYPASS_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module decode_stage_sb
    import decode_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_N  = 32,
    parameter int CTRL_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] if_pc,
    input  logic [31:0]       if_instr,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ex_pc,
    output logic [31:0]       ex_instr,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [4:0]        ex_dst,
    output logic              ex_wr,
    output logic              ex_illegal,
    output logic              halted
);

    localparam int AW = (REG_N > 1) ? $clog2(REG_N) : 1;

    logic [DATA_W-1:0] r_rf [REG_N];
    logic              r_out_valid;
    logic              r_halted;
    logic [DATA_W-1:0] r_pc;
    logic [31:0]       r_instr;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic [CTRL_W-1:0] r_ctrl;
    logic [4:0]        r_dst;
    logic              r_wr;
    logic              r_illegal;

    logic [OP_W-1:0]   w_op;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [4:0]        w_rd;
    logic [15:0]       w_imm16;
    dec_t              w_dec;
    logic [4:0]        w_dst;
    logic [CTRL_W-1:0] w_ctrl;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;
    logic              w_hazard;
    logic              w_accept;
    logic              w_flush_clr;

    assign w_op    = if_instr[F_OP_HI:F_OP_LO];
    assign w_rs    = if_instr[F_RS_HI:F_RS_LO];
    assign w_rt    = if_instr[F_RT_HI:F_RT_LO];
    assign w_rd    = if_instr[F_RD_HI:F_RD_LO];
    assign w_imm16 = if_instr[F_IMM_HI:F_IMM_LO];
    assign w_dec   = decode_ctrl(w_op);
    assign w_dst   = !w_dec.wr ? 5'd0 : (w_dec.dst_rt ? w_rt : w_rd);

    always_comb begin
        w_ctrl           = '0;
        w_ctrl[CTRL_N-1:0] = w_dec.ctrl;
    end

    always_comb begin
        w_rs_data = r_rf[w_rs[AW-1:0]];
        w_rt_data = r_rf[w_rt[AW-1:0]];
`ifdef WB_BYPASS_EN
        if (wb_en && (wb_addr[AW-1:0] == w_rs[AW-1:0])) w_rs_data = wb_data;
        if (wb_en && (wb_addr[AW-1:0] == w_rt[AW-1:0])) w_rt_data = wb_data;
`endif
    end

    assign in_ready    = !reset && !r_halted && !flush && !w_hazard
                         && (!r_out_valid || out_ready);
    assign w_accept    = in_valid && in_ready;
    // Only a live ID_EX entry owns its pending bit; a retired one is in execute.
    assign w_flush_clr = flush && r_out_valid && r_wr;

    decode_scoreboard #(
        .REG_N (REG_N)
    ) u_sb (
        .clk          (clock),
        .rst          (reset),
        .i_set_en     (w_accept && w_dec.wr),
        .i_set_addr   (w_dst),
        .i_clr_en     (wb_en),
        .i_clr_addr   (wb_addr),
        .i_flush_en   (w_flush_clr),
        .i_flush_addr (r_dst),
        .i_use_src    (w_dec.use_src),
        .i_rs         (w_rs),
        .i_rt         (w_rt),
        .o_hazard     (w_hazard)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < REG_N; i++) r_rf[i] <= '0;
        end else if (wb_en) begin
            r_rf[wb_addr[AW-1:0]] <= wb_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_halted    <= 1'b0;
            r_pc        <= '0;
            r_instr     <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_ctrl      <= '0;
            r_dst       <= '0;
            r_wr        <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_pc        <= if_pc;
            r_instr     <= if_instr;
            r_rs_data   <= w_rs_data;
            r_rt_data   <= w_rt_data;
            r_imm       <= {{(DATA_W-16){w_imm16[15]}}, w_imm16};
            r_ctrl      <= w_ctrl;
            r_dst       <= w_dst;
            r_wr        <= w_dec.wr;
            r_illegal   <= w_dec.illegal;
            if (w_op == OP_HLT) r_halted <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign halted     = r_halted;
    assign ex_pc      = r_pc;
    assign ex_instr   = r_instr;
    assign ex_rs_data = r_rs_data;
    assign ex_rt_data = r_rt_data;
    assign ex_imm     = r_imm;
    assign ex_ctrl    = r_ctrl;
    assign ex_dst     = r_dst;
    assign ex_wr      = r_wr;
    assign ex_illegal = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage_sb.sv
// ============================================================================
// tb_decode_stage_sb : directed self-checking bench for decode_stage_sb.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_decode_stage_sb;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ex_pc;
    logic [31:0] ex_instr;
    logic [31:0] ex_rs_data;
    logic [31:0] ex_rt_data;
    logic [31:0] ex_imm;
    logic [15:0] ex_ctrl;
    logic [4:0]  ex_dst;
    logic        ex_wr;
    logic        ex_illegal;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] w_sub;
    logic [31:0] w_or;

    always #5 clock = ~clock;

    decode_stage_sb #(
        .DATA_W (32),
        .REG_N  (32),
        .CTRL_W (16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ex_pc      (ex_pc),
        .ex_instr   (ex_instr),
        .ex_rs_data (ex_rs_data),
        .ex_rt_data (ex_rt_data),
        .ex_imm     (ex_imm),
        .ex_ctrl    (ex_ctrl),
        .ex_dst     (ex_dst),
        .ex_wr      (ex_wr),
        .ex_illegal (ex_illegal),
        .halted     (halted)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Advance past the next rising edge; outputs are stable 1 time unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; if_pc = '0; if_instr = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready, 0);
        chk("rst_halted",    halted, 0);
        chk("rst_ctrl",      ex_ctrl, 0);

        reset = 1'b0;
        #1;
        chk("idle_in_ready", in_ready, 1);

        // ADD r3, r1, r2
        if_instr = mk(6'd0, 5'd1, 5'd2, 16'h1800); if_pc = 32'h100;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("add_valid", out_valid, 1);
        chk("add_ctrl",  ex_ctrl, 16'h0001);
        chk("add_dst",   ex_dst, 3);
        chk("add_wr",    ex_wr, 1);
        chk("add_rs",    ex_rs_data, 0);
        chk("add_rt",    ex_rt_data, 0);
        chk("add_pc",    ex_pc, 32'h100);

        // Writeback r1, then ADI r6, r1, -2
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h0999_9999;
        tick();
        wb_en = 1'b0;
        chk("retire_valid", out_valid, 0);
        if_instr = mk(6'd11, 5'd1, 5'd6, 16'hFFFE); in_valid = 1'b1;
        tick();
        chk("adi_rs",   ex_rs_data, 32'h0999_9999);
        chk("adi_imm",  ex_imm, 32'hFFFF_FFFE);
        chk("adi_ctrl", ex_ctrl, 16'h0800);
        chk("adi_dst",  ex_dst, 6);

        // SUB r4, r3, r1 stalls on pending r3
        w_sub = mk(6'd1, 5'd3, 5'd1, 16'h2000);
        if_instr = w_sub;
        #1;
        chk("raw_stall0", in_ready, 0);
        tick(); tick();
        chk("raw_stall2", in_ready, 0);
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_0033;
        #1;
`ifdef WB_BYPASS_EN
        chk("wb_cycle_ready", in_ready, 1);
        tick();
        wb_en = 1'b0;
`else
        chk("wb_cycle_ready", in_ready, 0);
        tick();
        wb_en = 1'b0;
        chk("wb_cycle_novalid", out_valid, 0);
        #1;
        chk("post_wb_ready", in_ready, 1);
        tick();
`endif
        chk("sub_valid", out_valid, 1);
        chk("sub_ctrl",  ex_ctrl, 16'h0002);
        chk("sub_rs",    ex_rs_data, 32'h33);
        chk("sub_rt",    ex_rt_data, 32'h0999_9999);
        chk("sub_dst",   ex_dst, 4);

        // Back-pressure: OR r7, r2, r2 waits while execute is busy
        w_or = mk(6'd6, 5'd2, 5'd2, 16'h3800);
        out_ready = 1'b0; if_instr = w_or;
        #1;
        chk("hold_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_instr", ex_instr, w_sub);
            chk("hold_valid", out_valid, 1);
            chk("hold_rs",    ex_rs_data, 32'h33);
        end
        out_ready = 1'b1;
        #1;
        chk("release_ready", in_ready, 1);
        tick();
        chk("or_instr", ex_instr, w_or);
        chk("or_ctrl",  ex_ctrl, 16'h0040);

        // ADD r5, r0, r0 then flush it
        if_instr = mk(6'd0, 5'd0, 5'd0, 16'h2800);
        tick();
        chk("add5_dst", ex_dst, 5);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
        #1;
        chk("flush_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        chk("flush_valid", out_valid, 0);
        if_instr = mk(6'd5, 5'd5, 5'd0, 16'h4000); in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("post_flush_ready", in_ready, 1);
        tick();
        chk("and_valid", out_valid, 1);
        chk("and_ctrl",  ex_ctrl, 16'h0020);
        chk("and_dst",   ex_dst, 8);

        // Illegal opcode
        if_instr = mk(6'h3F, 5'd0, 5'd0, 16'h0000);
        tick();
        chk("ill_ctrl",  ex_ctrl, 16'h4000);
        chk("ill_flag",  ex_illegal, 1);
        chk("ill_wr",    ex_wr, 0);
        chk("ill_dst",   ex_dst, 0);

        // HLT freezes the stage
        if_instr = mk(6'd13, 5'd0, 5'd0, 16'h0000);
        tick();
        chk("hlt_halted", halted, 1);
        chk("hlt_ctrl",   ex_ctrl, 16'h2000);
        chk("hlt_valid",  out_valid, 1);
        if_instr = mk(6'd0, 5'd9, 5'd9, 16'h0800);
        #1;
        chk("hlt_ready", in_ready, 0);
        tick();
        chk("hlt_ready2", in_ready, 0);
        chk("hlt_retire", out_valid, 0);

        reset = 1'b1; in_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("rst2_halted", halted, 0);
        chk("rst2_ready",  in_ready, 1);
        chk("rst2_valid",  out_valid, 0);

        // r6/r4 were pending and r3 held data before reset
        if_instr = mk(6'd0, 5'd3, 5'd6, 16'h4800); in_valid = 1'b1;
        #1;
        chk("rst2_nostall", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("rst2_rs", ex_rs_data, 0);
        chk("rst2_valid1", out_valid, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
